// File: rtl/uart_pkg.sv
// Shared UART constants, arbiter state encoding and an index-width helper.
package uart_pkg;

  localparam int BAUD_DIV    = 2604;
  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: zero latency, search starts after last_grant and wraps.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic [IW-1:0]      winner,
  output logic               any_req
);

  // Walk from the farthest offset down so the closest requester after last_grant wins.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(last_grant) + k) % NUM_REQ]) begin
        winner  = IW'((int'(last_grant) + k) % NUM_REQ);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART serializer; grant pulses req_ready/tx_start one cycle after req_valid is seen in IDLE.
// Requesters hold req_valid until accepted; start-timeout recovery only when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int DATA_W      = UART_DATA_W,
  parameter  int TIMEOUT_CYC = 8192,
  localparam int IW          = idx_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         tx_din,
  output logic                      tx_start,
  input  logic                      tx_busy,
  output logic [IW-1:0]             grant_id,
  output logic                      arb_busy,
  output logic                      timeout_err
);

  arb_state_t    state, state_nxt;
  logic [IW-1:0] winner;
  logic [IW-1:0] last_grant;
  logic          any_req;
  logic          grant;
  logic          tmo;

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .winner     (winner),
    .any_req    (any_req)
  );

  // A busy serializer in IDLE belongs to someone else; hold off until it is free.
  assign grant = (state == IDLE) && any_req && !tx_busy;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_cnt <= '0;
    end else if (state == WAIT_BUSY) begin
      tmo_cnt <= tmo_cnt + CW'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end

  // First WAIT_BUSY edge is two edges after the grant, so the pulse lands TIMEOUT_CYC after tx_start.
  assign tmo = (state == WAIT_BUSY) && !tx_busy && (tmo_cnt == CW'(TIMEOUT_CYC - 2));
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYC > 0);
  assign tmo        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (grant) state_nxt = START;
      START:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (tmo) begin
          state_nxt = IDLE;
        end
      end
      WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_start  = (state == START);
    arb_busy  = (state != IDLE);
    req_ready = '0;
    if (state == START) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  // tx_din only moves at a grant edge, so it stays stable for the serializer's whole frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_din      <= '0;
      grant_id    <= '0;
      last_grant  <= IW'(NUM_REQ - 1);
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= tmo;
      if (grant) begin
        tx_din     <= req_data[winner*DATA_W +: DATA_W];
        grant_id   <= winner;
        last_grant <= winner;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a cycle-level reference model and a short-frame serializer model.
module tb_uart_tx_arbiter;

  localparam int N      = 4;
  localparam int DW     = 8;
  localparam int TCYC   = 300;
  localparam int SERLEN = 12;
`ifdef UART_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]  req_ready;
  logic [DW-1:0] tx_din;
  logic          tx_start;
  logic          tx_busy = 1'b0;
  logic [1:0]    grant_id;
  logic          arb_busy;
  logic          timeout_err;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT_CYC(TCYC)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_din      (tx_din),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .arb_busy    (arb_busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one frame is owned from the grant edge until tx_busy has been seen and has fallen.
  bit       m_st = 0, m_act = 0, m_seen = 0, m_tmo = 0;
  logic [7:0] m_din = '0;
  int       m_gid = 0, m_last = N - 1, m_cyc = 0, m_g = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_st = 0; m_act = 0; m_seen = 0; m_tmo = 0;
      m_din = '0; m_gid = 0; m_last = N - 1; m_cyc = 0; m_g = 0;
    end else begin
      bit found;
      m_cyc++;
      m_tmo = 0;
      found = 0;
      if (m_st) begin
        m_st = 0;
      end else if (m_act) begin
        if (!m_seen) begin
          if (tx_busy) m_seen = 1;
          else if (TMO_EN && (m_cyc - m_g == TCYC)) begin
            m_act = 0;
            m_tmo = 1;
          end
        end else if (!tx_busy) begin
          m_act = 0;
        end
      end else if (!tx_busy && req_valid != '0) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (!found && req_valid[c]) begin
            found  = 1;
            m_gid  = c;
            m_last = c;
            m_din  = req_data[c*DW +: DW];
          end
        end
        m_st = 1; m_act = 1; m_seen = 0; m_g = m_cyc;
      end
    end
  end

  // Producer queues, serializer model and grant log, all owned by the main process.
  logic [7:0] q_dat [N][32];
  int wr_ptr [N];
  int rd_ptr [N];
  int ncyc = 0, sc = 0, last_fall = 0, nlog = 0;
  bit foreign_busy = 0, ser_dead = 0;
  int log_gid [64], log_din [64], log_rr [64], log_cyc [64], log_gap [64];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 30)
        $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, ncyc, act, exp);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (rd_ptr[i] != wr_ptr[i]);
      req_data[i*DW +: DW] = req_valid[i] ? q_dat[i][rd_ptr[i] % 32] : 8'h00;
    end
  endtask

  task automatic push(input int i, input logic [7:0] b);
    q_dat[i][wr_ptr[i] % 32] = b;
    wr_ptr[i]++;
    drive_reqs();
  endtask

  task automatic tick();
    @(negedge clk);
    ncyc++;
    chk("tx_start",    32'(tx_start),    32'(m_st));
    chk("req_ready",   32'(req_ready),   m_st ? (32'd1 << m_gid) : 32'd0);
    chk("tx_din",      32'(tx_din),      32'(m_din));
    chk("grant_id",    32'(grant_id),    32'(m_gid));
    chk("arb_busy",    32'(arb_busy),    32'(m_act));
    chk("timeout_err", 32'(timeout_err), 32'(m_tmo));
    chk("onehot",      32'($countones(req_ready) <= 1), 32'd1);
    if (tx_start === 1'b1 && nlog < 64) begin
      log_gid[nlog] = int'(grant_id);
      log_din[nlog] = int'(tx_din);
      log_rr[nlog]  = int'(req_ready);
      log_cyc[nlog] = ncyc;
      log_gap[nlog] = ncyc - last_fall;
      nlog++;
    end
    for (int i = 0; i < N; i++)
      if (req_ready[i] === 1'b1) rd_ptr[i]++;
    if (!rstn) sc = 0;
    else if (sc == 0) begin
      if (tx_start === 1'b1 && !ser_dead) sc = 1;
    end else if (sc >= SERLEN) begin
      sc = 0;
      last_fall = ncyc;
    end else sc++;
    tx_busy = (sc != 0) || foreign_busy;
    drive_reqs();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic wait_log(input int n, input int budget, input string nm);
    for (int i = 0; i < budget && nlog < n; i++) tick();
    chk(nm, 32'(nlog >= n), 32'd1);
  endtask

  task automatic wait_busy(input int budget);
    for (int i = 0; i < budget && tx_busy !== 1'b1; i++) tick();
    chk("wait_busy", 32'(tx_busy), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && (arb_busy !== 1'b0 || tx_busy !== 1'b0); i++) tick();
    chk("wait_idle", 32'(arb_busy | tx_busy), 32'd0);
  endtask

  int b;
  int ids  [5] = '{0, 1, 2, 3, 0};
  int dins [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h15};

  initial begin
    for (int i = 0; i < N; i++) begin
      wr_ptr[i] = 0;
      rd_ptr[i] = 0;
    end
    drive_reqs();
    tick(); tick();
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_tx_din", 32'(tx_din), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_arb_busy", 32'(arb_busy), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    rstn = 1'b1;
    tick();

    // Single requester 2 with 0xA5
    b = nlog;
    push(2, 8'hA5);
    chk("t1_no_start_yet", 32'(tx_start), 32'd0);
    tick();
    chk("t1_start", 32'(tx_start), 32'd1);
    chk("t1_ready", 32'(req_ready), 32'h4);
    chk("t1_gid", 32'(grant_id), 32'd2);
    chk("t1_din", 32'(tx_din), 32'hA5);
    wait_busy(10);
    wait_idle(40);
    chk("t1_din_held", 32'(tx_din), 32'hA5);
    chk("t1_one_grant", 32'(nlog - b), 32'd1);

    // All four requesters valid: grants 0,1,2,3,0
    do_reset();
    b = nlog;
    push(0, 8'h11); push(0, 8'h15);
    push(1, 8'h22); push(2, 8'h33); push(3, 8'h44);
    wait_log(b + 5, 200, "t2_five_grants");
    for (int k = 0; k < 5; k++) begin
      chk("t2_gid", 32'(log_gid[b+k]), 32'(ids[k]));
      chk("t2_din", 32'(log_din[b+k]), 32'(dins[k]));
      chk("t2_ready", 32'(log_rr[b+k]), 32'd1 << ids[k]);
    end
    wait_idle(40);

    // Requester 1 arrives while 3 is transmitting
    do_reset();
    b = nlog;
    push(3, 8'h3C);
    wait_busy(10);
    tick(); tick();
    push(1, 8'h5A);
    wait_log(b + 2, 60, "t3_two_grants");
    chk("t3_first_gid", 32'(log_gid[b]), 32'd3);
    chk("t3_second_gid", 32'(log_gid[b+1]), 32'd1);
    chk("t3_second_din", 32'(log_din[b+1]), 32'h5A);
    chk("t3_gap", 32'(log_gap[b+1]), 32'd2);
    wait_idle(40);

    // Reset asserted in WAIT_DONE
    do_reset();
    b = nlog;
    push(2, 8'h77);
    wait_busy(10);
    tick(); tick(); tick();
    chk("t4_in_frame", 32'(arb_busy), 32'd1);
    rstn = 1'b0;
    #1;
    chk("t4_rst_arb_busy", 32'(arb_busy), 32'd0);
    chk("t4_rst_tx_din", 32'(tx_din), 32'd0);
    chk("t4_rst_gid", 32'(grant_id), 32'd0);
    chk("t4_rst_start", 32'(tx_start), 32'd0);
    chk("t4_rst_ready", 32'(req_ready), 32'd0);
    tick(); tick();
    rstn = 1'b1;
    tick();
    push(3, 8'h30);
    push(0, 8'h10);
    wait_log(b + 3, 80, "t4_after_reset");
    chk("t4_first_gid", 32'(log_gid[b+1]), 32'd0);
    chk("t4_first_din", 32'(log_din[b+1]), 32'h10);
    chk("t4_second_gid", 32'(log_gid[b+2]), 32'd3);
    wait_idle(40);

    // Back-to-back bytes from requester 1
    do_reset();
    b = nlog;
    push(1, 8'h01); push(1, 8'h02); push(1, 8'h03);
    wait_log(b + 3, 120, "t5_three_frames");
    for (int k = 0; k < 3; k++) begin
      chk("t5_gid", 32'(log_gid[b+k]), 32'd1);
      chk("t5_din", 32'(log_din[b+k]), 32'(k + 1));
    end
    chk("t5_gap1", 32'(log_gap[b+1]), 32'd2);
    chk("t5_gap2", 32'(log_gap[b+2]), 32'd2);
    wait_idle(40);

    // Foreign serializer activity blocks a grant
    do_reset();
    b = nlog;
    foreign_busy = 1'b1;
    tx_busy = 1'b1;
    push(0, 8'h66);
    repeat (6) tick();
    chk("t6_no_grant", 32'(nlog - b), 32'd0);
    chk("t6_arb_idle", 32'(arb_busy), 32'd0);
    foreign_busy = 1'b0;
    tx_busy = (sc != 0);
    wait_log(b + 1, 10, "t6_grant_after");
    chk("t6_gid", 32'(log_gid[b]), 32'd0);
    chk("t6_din", 32'(log_din[b]), 32'h66);
    wait_idle(40);

`ifdef UART_ARB_TIMEOUT_EN
    // Serializer never answers: timeout, then a normal grant
    do_reset();
    b = nlog;
    ser_dead = 1'b1;
    push(2, 8'h99);
    wait_log(b + 1, 10, "t7_grant");
    for (int i = 0; i < TCYC + 20 && timeout_err !== 1'b1; i++) tick();
    chk("t7_tmo_seen", 32'(timeout_err), 32'd1);
    chk("t7_tmo_dist", 32'(ncyc - log_cyc[b]), 32'(TCYC));
    chk("t7_arb_busy", 32'(arb_busy), 32'd0);
    tick();
    chk("t7_tmo_pulse", 32'(timeout_err), 32'd0);
    ser_dead = 1'b0;
    push(3, 8'h4D);
    wait_log(b + 2, 10, "t7_regrant");
    chk("t7_gid", 32'(log_gid[b+1]), 32'd3);
    chk("t7_din", 32'(log_din[b+1]), 32'h4D);
    wait_idle(40);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
